// File: rtl/tl_pkg.sv
// Shared definitions for the traffic light controller and its side-street sensor.
package tl_pkg;

    // Side-sensor FSM state encoding, also exported on the debug port.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVING = 2'd2
    } sstate_e;

    // Lamp one-hot encoding used by the controller ({red, yellow, green}).
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // Default detector filtering and urgency thresholds.
    localparam int DEF_DEB_CYCLES = 4;
    localparam int DEF_MAX_WAIT   = 200;

endpackage

// File: rtl/det_debounce.sv
// Loop-detector front end: 2-FF synchroniser, debounce filter, rising-edge pulse.
module det_debounce
    import tl_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic det_raw_i,
    output logic level_o,
    output logic rise_o
);

    // DEB_CYCLES is limited to 1..15, so four bits always suffice.
    localparam int DW = 4;

    logic          s1_q, s2_q;
    logic          lvl_q, lvl_d;
    logic          lvl_prev_q;
    logic [DW-1:0] cnt_q, cnt_d;

    // Count cycles the synchronised input disagrees with the accepted level;
    // the level flips once the disagreement has lasted DEB_CYCLES samples.
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (s2_q != lvl_q) begin
            if (cnt_q == DW'(DEB_CYCLES - 1)) begin
                lvl_d = s2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, filter state and previous level for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            lvl_q      <= 1'b0;
            lvl_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_q       <= det_raw_i;
            s2_q       <= s1_q;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
            cnt_q      <= cnt_d;
        end
    end

    assign level_o = lvl_q;
    assign rise_o  = lvl_q & ~lvl_prev_q;

endmodule

// File: rtl/side_sensor_req.sv
// Side-street request generator: counts waiting vehicles, holds Dss until served.
// Optional stuck-detector supervision is built when SIDE_SENSOR_STUCK_EN is defined.
module side_sensor_req
    import tl_pkg::*;
#(
    parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int CNT_W        = 4,
    parameter int MAX_WAIT     = DEF_MAX_WAIT,
    parameter int WAIT_W       = 8,
    parameter int STUCK_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             Dreset,
    input  logic             det_raw,
    input  logic             forSG,
    output logic             Dss,
    output logic [CNT_W-1:0] veh_cnt,
    output logic             urgent,
    output logic [1:0]       sstate,
    output logic             det_fault
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    sstate_e           state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              urg_q, urg_d;
    logic              dss_q, dss_d;
    logic              forsg_q;
    logic              det_lvl, det_rise;
    logic              arrival, dss_force, sg_fall;

    det_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk_i     (clk),
        .rst_i     (Dreset),
        .det_raw_i (det_raw),
        .level_o   (det_lvl),
        .rise_o    (det_rise)
    );

`ifdef SIDE_SENSOR_STUCK_EN
    localparam int SW = $clog2(STUCK_CYCLES + 1);

    logic [SW-1:0] stuck_q, stuck_d;
    logic          fault_q, fault_d;

    // Measure how long the debounced level has stayed high; a detector that
    // never releases is latched as faulty until reset.
    always_comb begin
        stuck_d = '0;
        fault_d = fault_q;
        if (det_lvl) begin
            stuck_d = (stuck_q == SW'(STUCK_CYCLES)) ? stuck_q : stuck_q + 1'b1;
            if (stuck_q == SW'(STUCK_CYCLES - 1))
                fault_d = 1'b1;
        end
    end

    // Stuck timer and sticky fault flag.
    always_ff @(posedge clk or posedge Dreset) begin
        if (Dreset) begin
            stuck_q <= '0;
            fault_q <= 1'b0;
        end else begin
            stuck_q <= stuck_d;
            fault_q <= fault_d;
        end
    end

    // A faulted detector cannot be trusted to count, so keep requesting
    // service so the side street is still cycled.
    assign arrival   = det_rise & ~fault_q;
    assign dss_force = fault_d;
    assign det_fault = fault_q;
`else
    logic lvl_unused;
    assign lvl_unused = det_lvl | (|STUCK_CYCLES);
    assign arrival    = det_rise;
    assign dss_force  = 1'b0;
    assign det_fault  = 1'b0;
`endif

    assign sg_fall = forsg_q & ~forSG;

    // Request FSM: next state, vehicle count, wait timer, urgency and Dss.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        urg_d   = urg_q;
        case (state_q)
            IDLE: begin
                // Controller serving on its own: follow it, never request.
                if (forSG) begin
                    state_d = SERVING;
                end else if (arrival) begin
                    state_d = PENDING;
                    cnt_d   = CNT_W'(1);
                    wait_d  = '0;
                    urg_d   = 1'b0;
                end
            end
            PENDING: begin
                if (arrival && cnt_q != CNT_MAX)
                    cnt_d = cnt_q + 1'b1;
                if (wait_q != WAIT_MAX)
                    wait_d = wait_q + 1'b1;
                if (wait_q == WAIT_W'(MAX_WAIT - 1))
                    urg_d = 1'b1;
                if (forSG)
                    state_d = SERVING;
            end
            SERVING: begin
                // Vehicles arriving on green drive straight through.
                if (sg_fall) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    wait_d  = '0;
                    urg_d   = 1'b0;
                    if (arrival) begin
                        state_d = PENDING;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Dss only survives into SERVING if it was raised by a real request.
        dss_d = (state_d == PENDING) | ((state_d == SERVING) & dss_q) | dss_force;
    end

    // Registered FSM and output state.
    always_ff @(posedge clk or posedge Dreset) begin
        if (Dreset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
            urg_q   <= 1'b0;
            dss_q   <= 1'b0;
            forsg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            urg_q   <= urg_d;
            dss_q   <= dss_d;
            forsg_q <= forSG;
        end
    end

    assign Dss     = dss_q;
    assign veh_cnt = cnt_q;
    assign urgent  = urg_q;
    assign sstate  = state_q;

endmodule

// File: tb/tb_side_sensor_req.sv
// Directed bench for side_sensor_req with an expectation queue.
module tb_side_sensor_req;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             Dreset, det_raw, forSG;
    logic             Dss, urgent, det_fault;
    logic [CNT_W-1:0] veh_cnt;
    logic [1:0]       sstate;

    int vectors    = 0;
    int miscompares = 0;

    typedef enum int {S_DSS, S_CNT, S_URG, S_ST, S_FLT} sig_e;
    typedef struct {
        string tag;
        sig_e  sig;
        int    val;
    } exp_t;
    exp_t sb[$];

    side_sensor_req #(
        .DEB_CYCLES  (4),
        .CNT_W       (CNT_W),
        .MAX_WAIT    (20),
        .WAIT_W      (8),
        .STUCK_CYCLES(50)
    ) dut (
        .clk      (clk),
        .Dreset   (Dreset),
        .det_raw  (det_raw),
        .forSG    (forSG),
        .Dss      (Dss),
        .veh_cnt  (veh_cnt),
        .urgent   (urgent),
        .sstate   (sstate),
        .det_fault(det_fault)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_v(input string tag, input sig_e s, input int v);
        exp_t e;
        e.tag = tag; e.sig = s; e.val = v;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input sig_e s);
        case (s)
            S_DSS:   return {31'd0, Dss};
            S_CNT:   return {30'd0, veh_cnt};
            S_URG:   return {31'd0, urgent};
            S_ST:    return {30'd0, sstate};
            default: return {31'd0, det_fault};
        endcase
    endfunction

    task automatic check_sb();
        exp_t        e;
        logic [31:0] obs;
        logic [31:0] want;
        while (sb.size() > 0) begin
            e    = sb.pop_front();
            obs  = observe(e.sig);
            want = e.val;
            vectors++;
            assert (obs === want) else begin
                miscompares++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, want);
            end
        end
    endtask

    task automatic vehicle();
        det_raw = 1'b1; cyc(10);
        det_raw = 1'b0; cyc(10);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        Dreset = 1'b1; det_raw = 1'b0; forSG = 1'b0;
        // Reset held with a toggling detector.
        repeat (5) begin
            @(posedge clk); #1;
            det_raw = ~det_raw;
        end
        exp_v("rst_dss", S_DSS, 0); exp_v("rst_cnt", S_CNT, 0);
        exp_v("rst_urg", S_URG, 0); exp_v("rst_st", S_ST, 0);
        exp_v("rst_flt", S_FLT, 0);
        check_sb();
        Dreset = 1'b0; det_raw = 1'b0; cyc(8);

        // 3-cycle glitch is rejected.
        det_raw = 1'b1; cyc(3); det_raw = 1'b0; cyc(12);
        exp_v("glitch_dss", S_DSS, 0); exp_v("glitch_st", S_ST, 0);
        check_sb();

        // 4-cycle pulse: Dss rises exactly 7 cycles after the raw rise.
        det_raw = 1'b1; cyc(4); det_raw = 1'b0; cyc(2);
        exp_v("pulse_dss_early", S_DSS, 0);
        check_sb();
        cyc(1);
        exp_v("pulse_dss", S_DSS, 1); exp_v("pulse_cnt", S_CNT, 1);
        exp_v("pulse_st", S_ST, 1);
        check_sb();

        // Urgency exactly 20 cycles after entering PENDING.
        cyc(19);
        exp_v("urg_early", S_URG, 0);
        check_sb();
        cyc(1);
        exp_v("urg_set", S_URG, 1);
        check_sb();

        // Two more vehicles while pending.
        vehicle(); vehicle();
        exp_v("count3", S_CNT, 3); exp_v("count3_dss", S_DSS, 1);
        check_sb();

        // Serve: arrivals on green are not counted.
        forSG = 1'b1; cyc(2);
        exp_v("serve_st", S_ST, 2); exp_v("serve_dss", S_DSS, 1);
        check_sb();
        vehicle(); vehicle();
        exp_v("serve_cnt", S_CNT, 3); exp_v("serve_urg", S_URG, 1);
        check_sb();
        forSG = 1'b0; cyc(1);
        exp_v("exit_st", S_ST, 0); exp_v("exit_cnt", S_CNT, 0);
        exp_v("exit_dss", S_DSS, 0); exp_v("exit_urg", S_URG, 0);
        check_sb();

        // Saturation at 2^CNT_W-1.
        repeat (5) vehicle();
        exp_v("sat_cnt", S_CNT, 3); exp_v("sat_st", S_ST, 1);
        check_sb();

        // Arrival coincident with the forSG fall re-enters PENDING.
        forSG = 1'b1; cyc(3);
        exp_v("sim_serving", S_ST, 2);
        check_sb();
        det_raw = 1'b1; cyc(6);
        forSG = 1'b0; cyc(1);
        exp_v("sim_st", S_ST, 1); exp_v("sim_cnt", S_CNT, 1);
        exp_v("sim_dss", S_DSS, 1); exp_v("sim_urg", S_URG, 0);
        check_sb();
        cyc(3); det_raw = 1'b0; cyc(10);
        forSG = 1'b1; cyc(2); forSG = 1'b0; cyc(1);
        exp_v("sim_clear_st", S_ST, 0);
        check_sb();

        // Spontaneous service from IDLE never raises Dss.
        forSG = 1'b1; cyc(2);
        exp_v("spont_st", S_ST, 2); exp_v("spont_dss", S_DSS, 0);
        check_sb();
        forSG = 1'b0; cyc(1);
        exp_v("spont_back", S_ST, 0);
        check_sb();

        // Reset mid-request drops Dss without a clock edge.
        vehicle();
        exp_v("mid_dss", S_DSS, 1);
        check_sb();
        Dreset = 1'b1; #2;
        exp_v("async_dss", S_DSS, 0); exp_v("async_cnt", S_CNT, 0);
        exp_v("async_st", S_ST, 0);
        check_sb();
        cyc(1); Dreset = 1'b0; cyc(3);

        // Detector held high: stuck fault only when the feature is built.
        det_raw = 1'b1; cyc(70);
`ifdef SIDE_SENSOR_STUCK_EN
        exp_v("stuck_flt", S_FLT, 1);
`else
        exp_v("stuck_flt", S_FLT, 0);
`endif
        exp_v("stuck_dss", S_DSS, 1);
        check_sb();
        forSG = 1'b1; cyc(3); forSG = 1'b0; cyc(2);
`ifdef SIDE_SENSOR_STUCK_EN
        exp_v("stuck_hold_dss", S_DSS, 1);
`else
        exp_v("stuck_hold_dss", S_DSS, 0);
`endif
        exp_v("stuck_hold_st", S_ST, 0);
        check_sb();
        Dreset = 1'b1; #2;
        exp_v("stuck_rst_dss", S_DSS, 0); exp_v("stuck_rst_flt", S_FLT, 0);
        check_sb();
        cyc(1); Dreset = 1'b0; det_raw = 1'b0; cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
